ptp_extts_sched: RTL and testbench

PTP_EXTTS_SCHED -- requirements
Module: ptp_extts_sched

---
 rtl/ptp_extts_sched_pkg.sv | 13 +
 rtl/ptp_extts_evt_fifo.sv | 53 +++++
 rtl/ptp_extts_sched.sv | 149 ++++++++++++++
 tb/tb_ptp_extts_sched.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ptp_extts_sched_pkg.sv
// Shared types for the external-timestamp scheduler: FSM states and event layout.
package ptp_extts_sched_pkg;
    localparam int TS_W = 96;
    localparam int CH_W = 3;

    typedef enum logic [1:0] {IDLE, CAPTURE, ARM, SETTLE} state_t;

    // FIFO entry: channel index above the 96-bit timestamp.
    typedef struct packed {
        logic [CH_W-1:0] ch;
        logic [TS_W-1:0] ts;
    } evt_t;
endpackage

// File: rtl/ptp_extts_evt_fifo.sv
// First-word-fall-through event FIFO with synchronous flush.
module ptp_extts_evt_fifo
    import ptp_extts_sched_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        push,
    input  evt_t        wdata,
    input  logic        pop,
    output evt_t        rdata,
    output logic        valid,
    output logic        full,
    output logic [AW:0] count
);
    logic [AW-1:0] wr_ptr, rd_ptr;
    evt_t          mem [DEPTH];
    logic          do_push, do_pop;

    assign valid   = (count != '0);
    assign full    = (count == (AW+1)'(DEPTH));
    // A flush discards anything pushed or popped in the same cycle.
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & valid & ~flush;
    // Head reads as zero while empty so the outputs are clean after reset.
    assign rdata   = valid ? mem[rd_ptr] : '0;

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

    // Storage array; contents only matter while counted as valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/ptp_extts_sched.sv
// Round-robin scheduler that drains locked timestamp latchers into an event FIFO.
module ptp_extts_sched
    import ptp_extts_sched_pkg::*;
#(
    parameter int CH_COUNT       = 4,
    parameter int FIFO_DEPTH     = 8,
    parameter int SETTLE_TIMEOUT = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [CH_COUNT-1:0]          ch_enable,
    input  logic [CH_COUNT-1:0]          ch_locked,
    input  logic [CH_COUNT*TS_W-1:0]     ch_ts,
    output logic [CH_COUNT-1:0]          ch_arm,
    output logic [TS_W-1:0]              out_ts,
    output logic [2:0]                   out_ch,
    output logic                         out_valid,
    input  logic                         out_ready,
    input  logic                         flush,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         full_stall,
    output logic                         arm_timeout,
    input  logic                         status_clear
);
    localparam int CW = $clog2(SETTLE_TIMEOUT+1);

    state_t          state, state_nx;
    logic [2:0]      grant, grant_nx, rr_ptr, rr_nx, sel, rr_next;
    logic [CW-1:0]   scnt, scnt_nx;
    logic [7:0]      req8, lk8, en8;
    logic [3:0]      idx;
    logic            found, push, fifo_full, to_set, stall_set;
    logic [TS_W-1:0] ts_arr [8];
    evt_t            wdata, rdata;

    // Pad per-channel vectors to 8 so a 3-bit channel index always fits.
    assign lk8  = 8'(ch_locked);
    assign en8  = 8'(ch_enable);
    assign req8 = 8'(ch_locked & ch_enable);

    for (genvar i = 0; i < 8; i++) begin : g_ts
        if (i < CH_COUNT) begin : g_on
            assign ts_arr[i] = ch_ts[i*TS_W +: TS_W];
        end else begin : g_off
            assign ts_arr[i] = '0;
        end
    end

    assign rr_next   = (grant == 3'(CH_COUNT-1)) ? 3'd0 : grant + 3'd1;
    assign wdata     = '{ch: grant, ts: ts_arr[grant]};
    assign stall_set = (req8 != 8'd0) && fifo_full;

    // Round-robin pick: first requesting channel at or after rr_ptr, wrapping.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < CH_COUNT; k++) begin
            idx = {1'b0, rr_ptr} + 4'(k);
            if (idx >= 4'(CH_COUNT)) idx = idx - 4'(CH_COUNT);
            if (!found && req8[idx[2:0]]) begin
                found = 1'b1;
                sel   = idx[2:0];
            end
        end
    end

    // Next-state and per-state outputs; dropping enable abandons the grant.
    always_comb begin
        state_nx = state;
        grant_nx = grant;
        rr_nx    = rr_ptr;
        scnt_nx  = scnt;
        push     = 1'b0;
        to_set   = 1'b0;
        ch_arm   = '0;
        if (!enable) begin
            state_nx = IDLE;
            if (state == SETTLE) rr_nx = rr_next;
        end else begin
            case (state)
                IDLE: begin
                    if (found && !fifo_full) begin
                        grant_nx = sel;
                        state_nx = CAPTURE;
                    end
                end
                CAPTURE: begin
                    push     = 1'b1;
                    state_nx = ARM;
                end
                ARM: begin
                    ch_arm   = {{(CH_COUNT-1){1'b0}}, 1'b1} << grant;
                    scnt_nx  = '0;
                    state_nx = SETTLE;
                end
                SETTLE: begin
                    if (!lk8[grant] || !en8[grant]) begin
                        state_nx = IDLE;
                        rr_nx    = rr_next;
                    end else if (scnt == CW'(SETTLE_TIMEOUT-1)) begin
                        state_nx = IDLE;
                        rr_nx    = rr_next;
                        to_set   = 1'b1;
                    end else begin
                        scnt_nx  = scnt + 1'b1;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // State registers and sticky status; a set in the clear cycle wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            grant       <= '0;
            rr_ptr      <= '0;
            scnt        <= '0;
            full_stall  <= 1'b0;
            arm_timeout <= 1'b0;
        end else begin
            state       <= state_nx;
            grant       <= grant_nx;
            rr_ptr      <= rr_nx;
            scnt        <= scnt_nx;
            full_stall  <= stall_set | (full_stall & ~status_clear);
            arm_timeout <= to_set | (arm_timeout & ~status_clear);
        end
    end

    ptp_extts_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .wdata (wdata),
        .pop   (out_ready),
        .rdata (rdata),
        .valid (out_valid),
        .full  (fifo_full),
        .count (fifo_count)
    );

    assign out_ts = rdata.ts;
    assign out_ch = rdata.ch;
endmodule

// File: tb/tb_ptp_extts_sched.sv
// Scenario bench for ptp_extts_sched with a latcher model and FIFO scoreboard.
module tb_ptp_extts_sched;
    localparam int CH = 4;

    logic            clk = 1'b0;
    logic            rst, enable, out_ready, flush, status_clear;
    logic [CH-1:0]   ch_enable, ch_locked, ch_arm;
    logic [CH*96-1:0] ch_ts;
    logic [95:0]     out_ts;
    logic [2:0]      out_ch;
    logic            out_valid, full_stall, arm_timeout;
    logic [3:0]      fifo_count;

    // Latcher model state and scoreboard.
    logic [CH-1:0]   lk;
    logic [95:0]     tsr [CH];
    logic [95:0]     nts [CH];
    int              pend [CH];
    int              age [CH];
    int              arm_cnt [CH];
    bit              stuck [CH];
    int              cyc;
    logic [98:0]     exp_q [$];
    int              arm_q [$];
    int              arm_cyc [$];
    logic [98:0]     e;
    int              checks = 0, errors = 0;

    ptp_extts_sched #(.CH_COUNT(CH), .FIFO_DEPTH(8), .SETTLE_TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .enable(enable), .ch_enable(ch_enable),
        .ch_locked(ch_locked), .ch_ts(ch_ts), .ch_arm(ch_arm),
        .out_ts(out_ts), .out_ch(out_ch), .out_valid(out_valid),
        .out_ready(out_ready), .flush(flush), .fifo_count(fifo_count),
        .full_stall(full_stall), .arm_timeout(arm_timeout),
        .status_clear(status_clear)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Latcher model: relock from pending events, unlock on arm, consume the FIFO head.
    initial forever begin
        @(negedge clk);
        cyc++;
        for (int i = 0; i < CH; i++) begin
            if (!lk[i]) begin
                if (pend[i] > 0 && age[i] >= 1) begin
                    lk[i]  = 1'b1;
                    tsr[i] = nts[i];
                    nts[i] = nts[i] + 96'd1;
                    pend[i]--;
                end else if (age[i] < 1000) begin
                    age[i]++;
                end
            end
        end
        if (ch_arm != '0) begin
            checks++;
            if ($countones(ch_arm) != 1) begin
                errors++;
                $display("FAIL arm_onehot: ch_arm=%b, required exactly one bit", ch_arm);
            end
        end
        for (int i = 0; i < CH; i++) begin
            if (ch_arm[i]) begin
                arm_cnt[i]++;
                arm_q.push_back(i);
                arm_cyc.push_back(cyc);
                exp_q.push_back({3'(i), tsr[i]});
                if (!stuck[i]) begin
                    lk[i]  = 1'b0;
                    age[i] = 0;
                end
            end
        end
        if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_extra: popped ch=%0d ts=%h with nothing expected", out_ch, out_ts);
            end else begin
                e = exp_q.pop_front();
                if ({out_ch, out_ts} !== e) begin
                    errors++;
                    $display("FAIL scoreboard: got ch=%0d ts=%h, required ch=%0d ts=%h",
                             out_ch, out_ts, e[98:96], e[95:0]);
                end
            end
        end
        ch_locked = lk;
        for (int i = 0; i < CH; i++) ch_ts[i*96 +: 96] = tsr[i];
    end

    task automatic do_reset();
        rst = 1'b1; enable = 1'b1; ch_enable = '1; out_ready = 1'b0;
        flush = 1'b0; status_clear = 1'b0;
        lk = '0; ch_locked = '0; ch_ts = '0;
        for (int i = 0; i < CH; i++) begin
            pend[i] = 0; stuck[i] = 1'b0; age[i] = 1; arm_cnt[i] = 0;
            tsr[i] = '0; nts[i] = {32'(i + 1), 64'h1000};
        end
        exp_q.delete(); arm_q.delete(); arm_cyc.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, ch_arm, full_stall, arm_timeout} !== '0 || fifo_count !== 4'd0) begin
            errors++;
            $display("FAIL reset_state: valid=%b arm=%b stall=%b tmo=%b count=%0d, required all 0",
                     out_valid, ch_arm, full_stall, arm_timeout, fifo_count);
        end
        checks++;
        if (out_ts !== 96'd0 || out_ch !== 3'd0) begin
            errors++;
            $display("FAIL reset_head: ts=%h ch=%0d, required 0", out_ts, out_ch);
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_single();
        logic [95:0] t = 96'h0000_0000_0001_3B9A_C9FF_0000;
        do_reset();
        out_ready = 1'b1;
        nts[2] = t; pend[2] = 1;
        @(posedge clk); #1;
        checks++;
        if (ch_arm !== 4'b0000 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_n1: arm=%b valid=%b, required 0000/0", ch_arm, out_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (ch_arm !== 4'b0100 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_n2: arm=%b valid=%b, required 0100/1", ch_arm, out_valid);
        end
        checks++;
        if (out_ch !== 3'd2 || out_ts !== t) begin
            errors++;
            $display("FAIL single_head: ch=%0d ts=%h, required 2 %h", out_ch, out_ts, t);
        end
        repeat (6) @(posedge clk); #1;
        checks++;
        if (arm_cnt[2] != 1 || fifo_count !== 4'd0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL single_done: arms=%0d count=%0d pending=%0d, required 1/0/0",
                     arm_cnt[2], fifo_count, exp_q.size());
        end
    endtask

    task automatic test_fairness();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < CH; i++) pend[i] = 2;
        for (int t = 0; t < 300 && arm_q.size() < 8; t++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (arm_q.size() < 8) begin
            errors++;
            $display("FAIL fair_timeout: %0d grants seen, required 8", arm_q.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (arm_q[k] != k % 4) begin
                    errors++;
                    $display("FAIL fair_order[%0d]: got ch%0d, required ch%0d", k, arm_q[k], k % 4);
                end
            end
        end
        repeat (10) @(posedge clk); #1;
        for (int i = 0; i < CH; i++) begin
            checks++;
            if (arm_cnt[i] != 2) begin
                errors++;
                $display("FAIL fair_arms ch%0d: got %0d pulses, required 2", i, arm_cnt[i]);
            end
        end
        checks++;
        if (exp_q.size() != 0 || fifo_count !== 4'd0) begin
            errors++;
            $display("FAIL fair_drain: pending=%0d count=%0d, required 0/0", exp_q.size(), fifo_count);
        end
    endtask

    task automatic test_full();
        do_reset();
        pend[0] = 3; pend[1] = 2; pend[2] = 2; pend[3] = 2;
        for (int t = 0; t < 300 && fifo_count !== 4'd8; t++) begin
            @(posedge clk); #1;
        end
        repeat (20) @(posedge clk); #1;
        checks++;
        if (fifo_count !== 4'd8 || full_stall !== 1'b1) begin
            errors++;
            $display("FAIL full_state: count=%0d stall=%b, required 8/1", fifo_count, full_stall);
        end
        checks++;
        if (arm_cnt[0] != 2 || arm_q.size() != 8) begin
            errors++;
            $display("FAIL full_no_grant: ch0 arms=%0d total=%0d, required 2/8", arm_cnt[0], arm_q.size());
        end
        status_clear = 1'b1;
        @(posedge clk); #1 status_clear = 1'b0;
        checks++;
        if (full_stall !== 1'b1) begin
            errors++;
            $display("FAIL stall_set_wins: stall=%b, required 1", full_stall);
        end
        out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        repeat (10) @(posedge clk); #1;
        checks++;
        if (arm_cnt[0] != 3 || fifo_count !== 4'd8) begin
            errors++;
            $display("FAIL full_after_pop: ch0 arms=%0d count=%0d, required 3/8", arm_cnt[0], fifo_count);
        end
        out_ready = 1'b1;
        for (int t = 0; t < 100 && fifo_count !== 4'd0; t++) begin
            @(posedge clk); #1;
        end
        status_clear = 1'b1;
        @(posedge clk); #1 status_clear = 1'b0;
        checks++;
        if (exp_q.size() != 0 || fifo_count !== 4'd0 || full_stall !== 1'b0) begin
            errors++;
            $display("FAIL full_drain: pending=%0d count=%0d stall=%b, required 0/0/0",
                     exp_q.size(), fifo_count, full_stall);
        end
    endtask

    task automatic test_stuck();
        do_reset();
        out_ready = 1'b1;
        stuck[1] = 1'b1; pend[1] = 1; pend[2] = 1;
        for (int t = 0; t < 100 && arm_q.size() < 2; t++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (arm_q.size() < 2) begin
            errors++;
            $display("FAIL stuck_timeout: %0d grants seen, required 2", arm_q.size());
        end else begin
            checks++;
            if (arm_q[0] != 1 || arm_q[1] != 2) begin
                errors++;
                $display("FAIL stuck_order: got ch%0d,ch%0d, required ch1,ch2", arm_q[0], arm_q[1]);
            end
            checks++;
            if (arm_cyc[1] - arm_cyc[0] != 11) begin
                errors++;
                $display("FAIL stuck_gap: %0d cycles between arms, required 11", arm_cyc[1] - arm_cyc[0]);
            end
        end
        checks++;
        if (arm_timeout !== 1'b1) begin
            errors++;
            $display("FAIL stuck_flag: arm_timeout=%b, required 1", arm_timeout);
        end
        stuck[1] = 1'b0;
        repeat (60) @(posedge clk); #1;
        status_clear = 1'b1;
        @(posedge clk); #1 status_clear = 1'b0;
        checks++;
        if (arm_timeout !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL stuck_clear: arm_timeout=%b pending=%0d, required 0/0", arm_timeout, exp_q.size());
        end
    endtask

    task automatic test_disable();
        logic [95:0] t = 96'hDEAD_BEEF_0000_1111_2222_3333;
        do_reset();
        nts[0] = t; pend[0] = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        enable = 1'b0;
        #1;
        checks++;
        if (ch_arm !== 4'b0000 || fifo_count !== 4'd1 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL dis_arm: arm=%b count=%0d valid=%b, required 0000/1/1", ch_arm, fifo_count, out_valid);
        end
        repeat (5) @(posedge clk); #1;
        checks++;
        if (arm_cnt[0] != 0 || fifo_count !== 4'd1) begin
            errors++;
            $display("FAIL dis_hold: arms=%0d count=%0d, required 0/1", arm_cnt[0], fifo_count);
        end
        exp_q.push_back({3'd0, t});
        enable = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (ch_arm !== 4'b0001 || fifo_count !== 4'd2) begin
            errors++;
            $display("FAIL dis_resume: arm=%b count=%0d, required 0001/2", ch_arm, fifo_count);
        end
        out_ready = 1'b1;
        repeat (10) @(posedge clk); #1;
        checks++;
        if (fifo_count !== 4'd0 || exp_q.size() != 0 || arm_cnt[0] != 1) begin
            errors++;
            $display("FAIL dis_drain: count=%0d pending=%0d arms=%0d, required 0/0/1",
                     fifo_count, exp_q.size(), arm_cnt[0]);
        end
    endtask

    task automatic test_reset_flush();
        do_reset();
        pend[0] = 1; pend[1] = 1; pend[2] = 1;
        for (int t = 0; t < 100 && fifo_count !== 4'd3; t++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, ch_arm, full_stall, arm_timeout} !== '0 || fifo_count !== 4'd0 ||
            out_ts !== 96'd0 || out_ch !== 3'd0) begin
            errors++;
            $display("FAIL rst_mid: valid=%b arm=%b count=%0d ts=%h ch=%0d, required all 0",
                     out_valid, ch_arm, fifo_count, out_ts, out_ch);
        end
        exp_q.delete();
        @(posedge clk); #1 rst = 1'b0;
        pend[3] = 1;
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        checks++;
        if (fifo_count !== 4'd0 || out_valid !== 1'b0 || ch_arm !== 4'b1000) begin
            errors++;
            $display("FAIL flush_push: count=%0d valid=%b arm=%b, required 0/0/1000",
                     fifo_count, out_valid, ch_arm);
        end
        @(posedge clk); #1;
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_full();
        test_stuck();
        test_disable();
        test_reset_flush();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
